// File: rtl/mul_div_unit_if.sv
// Operand, control and result bundle between the EX stage and the HI/LO multiply/divide unit.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  mduOp;
  logic [31:0] din1;
  logic [31:0] din2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mduOp, din1, din2, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, mduOp, din1, din2, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (mult/multu/div/divu, mthi/mtlo).
// Define MDU_FAST_MUL_EN to compute mult/multu in a single cycle instead of 32 iterations.
module mul_div_unit (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  mdu
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic        div_q, div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        done_q, done_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] din1_q, din1_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign signed_op = ~mdu.mduOp[0];
  assign a_mag     = (signed_op && mdu.din1[31]) ? -mdu.din1 : mdu.din1;
  assign b_mag     = (signed_op && mdu.din2[31]) ? -mdu.din2 : mdu.din2;

  // Multiply: multiplier sits in acc[31:0] and is shifted out as the product shifts in.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  // Divide: dividend sits in acc[31:0]; quotient bits shift in at the bottom.
  assign div_shift = {rem_q, acc_q[31]};
  assign div_diff  = div_shift - {1'b0, b_q};

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quo_fix   = neg_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix   = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    din1_d  = din1_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (mdu.start) begin
          if (!mdu.mduOp[2]) begin
            div_d  = mdu.mduOp[1];
            neg_d  = signed_op & (mdu.din1[31] ^ mdu.din2[31]);
            rneg_d = signed_op & mdu.din1[31];
            a_d    = a_mag;
            b_d    = b_mag;
            din1_d = mdu.din1;
            cnt_d  = 6'd0;
            rem_d  = 32'd0;
`ifdef MDU_FAST_MUL_EN
            if (mdu.mduOp[1]) begin
              acc_d   = {32'd0, a_mag};
              state_d = StCalc;
            end else begin
              acc_d   = {32'd0, a_mag} * {32'd0, b_mag};
              state_d = StFix;
            end
`else
            acc_d   = mdu.mduOp[1] ? {32'd0, a_mag} : {32'd0, b_mag};
            state_d = StCalc;
`endif
          end else if (!mdu.mduOp[1]) begin
            if (mdu.mduOp[0]) lo_d = mdu.din1;
            else              hi_d = mdu.din1;
          end
        end
      end
      StCalc: begin
        if (div_q) begin
          if (!div_diff[32]) begin
            rem_d        = div_diff[31:0];
            acc_d[31:0]  = {acc_q[30:0], 1'b1};
          end else begin
            rem_d        = div_shift[31:0];
            acc_d[31:0]  = {acc_q[30:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (b_q == 32'd0) begin
          hi_d = din1_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over everything, including an mthi/mtlo issued in the same cycle.
    if (mdu.flush) begin
      state_d = StIdle;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      din1_q  <= 32'd0;
      rem_q   <= 32'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      din1_q  <= din1_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mdu.busy = (state_q != StIdle);
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic HI/LO reference model.
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
  localparam int MulCycles = 1;
`else
  localparam int MulCycles = 33;
`endif
  localparam int DivCycles = 33;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if mdu_if ();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int dones;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: {HI, LO} from plain arithmetic on the architectural operands.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'b000: begin
        sq = sa * sb;
        p  = sq;
      end
      3'b001: p = {32'd0, a} * {32'd0, b};
      3'b010: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
      3'b011: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else            p = {a % b, a / b};
      end
      default: p = {exp_hi, exp_lo};
    endcase
    return p;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int cycles;
    int nd;
    logic [63:0] r;
    @(negedge clk);
    mdu_if.start = 1'b1;
    mdu_if.mduOp = op;
    mdu_if.din1  = a;
    mdu_if.din2  = b;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    mdu_if.din1  = $urandom;
    mdu_if.din2  = $urandom;
    cycles = 0;
    nd = 0;
    while (mdu_if.busy && cycles < 100) begin
      cycles++;
      if (mdu_if.done) nd++;
      @(posedge clk);
      #1;
    end
    if (mdu_if.done) nd++;
    r = ref_result(op, a, b);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check({tag, ".busy_cycles"}, 64'(cycles), 64'(op[1] ? DivCycles : MulCycles));
    check({tag, ".done_pulses"}, 64'(nd), 64'd1);
    check({tag, ".hi"}, {32'd0, mdu_if.hi}, {32'd0, exp_hi});
    check({tag, ".lo"}, {32'd0, mdu_if.lo}, {32'd0, exp_lo});
    @(posedge clk);
    #1;
    check({tag, ".done_low"}, {63'd0, mdu_if.done}, 64'd0);
  endtask

  // Single-edge ops: mthi/mtlo, ignored 11x codes, optionally with flush asserted.
  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] a,
                    input logic fl);
    @(negedge clk);
    mdu_if.start = 1'b1;
    mdu_if.mduOp = op;
    mdu_if.din1  = a;
    mdu_if.flush = fl;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    mdu_if.flush = 1'b0;
    if (!fl && op == 3'b100) exp_hi = a;
    if (!fl && op == 3'b101) exp_lo = a;
    check({tag, ".busy"}, {63'd0, mdu_if.busy}, 64'd0);
    check({tag, ".done"}, {63'd0, mdu_if.done}, 64'd0);
    check({tag, ".hi"}, {32'd0, mdu_if.hi}, {32'd0, exp_hi});
    check({tag, ".lo"}, {32'd0, mdu_if.lo}, {32'd0, exp_lo});
  endtask

  initial begin
    rst          = 1'b1;
    mdu_if.start = 1'b0;
    mdu_if.mduOp = 3'b000;
    mdu_if.din1  = 32'd0;
    mdu_if.din2  = 32'd0;
    mdu_if.flush = 1'b0;
    #12;
    check("reset.busy", {63'd0, mdu_if.busy}, 64'd0);
    check("reset.done", {63'd0, mdu_if.done}, 64'd0);
    check("reset.hi", {32'd0, mdu_if.hi}, 64'd0);
    check("reset.lo", {32'd0, mdu_if.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mult_5_m3", 3'b000, 32'd5, 32'hFFFF_FFFD);
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_m1_m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_7_2", 3'b011, 32'd7, 32'd2);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_by0", 3'b011, 32'h1234_5678, 32'd0);
    run_op("div_m7_by0", 3'b010, 32'hFFFF_FFF9, 32'd0);
    run_op("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE);

    mt("mthi", 3'b100, 32'hAAAA_AAAA, 1'b0);
    mt("mtlo", 3'b101, 32'hAAAA_AAAA, 1'b0);
    mt("op110", 3'b110, 32'h0BAD_0BAD, 1'b0);
    mt("op111", 3'b111, 32'h0BAD_0BAD, 1'b0);
    mt("flush_mthi", 3'b100, 32'h1111_1111, 1'b1);

    // div 9/4, mthi attempted while busy at E5, flush at E10.
    @(negedge clk);
    mdu_if.start = 1'b1;
    mdu_if.mduOp = 3'b010;
    mdu_if.din1  = 32'd9;
    mdu_if.din2  = 32'd4;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    mdu_if.start = 1'b1;
    mdu_if.mduOp = 3'b100;
    mdu_if.din1  = 32'h5555_5555;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    check("busy_start.busy", {63'd0, mdu_if.busy}, 64'd1);
    check("busy_start.hi", {32'd0, mdu_if.hi}, 64'hAAAA_AAAA);
    repeat (4) @(posedge clk);
    @(negedge clk);
    mdu_if.flush = 1'b1;
    @(posedge clk);
    #1;
    mdu_if.flush = 1'b0;
    check("flush.busy", {63'd0, mdu_if.busy}, 64'd0);
    dones = 0;
    repeat (40) begin
      if (mdu_if.done) dones++;
      @(posedge clk);
      #1;
    end
    check("flush.no_done", 64'(dones), 64'd0);
    check("flush.hi", {32'd0, mdu_if.hi}, 64'hAAAA_AAAA);
    check("flush.lo", {32'd0, mdu_if.lo}, 64'hAAAA_AAAA);
    run_op("post_flush", 3'b011, 32'd100, 32'd7);

    // Async reset in the middle of an iteration.
    @(negedge clk);
    mdu_if.start = 1'b1;
    mdu_if.mduOp = 3'b000;
    mdu_if.din1  = 32'h0123_4567;
    mdu_if.din2  = 32'h89AB_CDEF;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("rst_mid.busy", {63'd0, mdu_if.busy}, 64'd0);
    check("rst_mid.hi", {32'd0, mdu_if.hi}, 64'd0);
    check("rst_mid.lo", {32'd0, mdu_if.lo}, 64'd0);
    #3;
    rst = 1'b0;
    mt("rst_mthi", 3'b100, 32'h1234_5678, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b);
      if ($urandom_range(0, 3) == 0)
        mt($sformatf("rnd_mt%0d", i), 3'($urandom_range(4, 7)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
